fetch_decode_queue: RTL and testbench
=====================================

Name: fetch_decode_queue

Overview:
- Consumer end of the fetch interface. Takes PC, PC_plus4 and instruction from the fetch stage every cycle and buffers them in a DEPTH-entry FIFO. Presents them to decode with a valid/ready handshake.
- Closes the loop back to fetch by driving PC_enable, next_PC and branch_taken.
- Handles backpressure from decode and flushes wrong-path instructions on a branch redirect from execute.

Parameters:
- DEPTH, 2, number of queue entries; power of two, at least 2.
- CNT_W, 2, width of count output; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- f_PC  input  64  PC of the instruction currently in the fetch stage.
- f_PC_plus4  input  64  f_PC + 4 from fetch.
- f_instruction  input  32  instruction word at f_PC; combinational read, valid the same cycle.
- PC_enable  output  1  fetch PC register load enable.
- next_PC  output  64  value loaded into the fetch PC register.
- branch_taken  output  1  high when next_PC is a redirect target.
- redirect  input  1  one-cycle pulse from branch resolution: flush and redirect.
- redirect_target  input  64  new PC; sampled only when redirect=1.
- d_valid  output  1  head entry available to decode.
- d_ready  input  1  decode accepts the head entry this cycle.
- d_PC  output  64  head entry PC.
- d_PC_plus4  output  64  head entry PC+4.
- d_instruction  output  32  head entry instruction.
- count  output  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries {PC, PC_plus4, instruction}; read and write pointers wrap modulo DEPTH; separate occupancy counter.
- Reset (reset=1 at an edge): pointers 0, count 0, d_valid 0. While reset is high, PC_enable=0 and branch_taken=0. Entry contents are don't-care.
- Reset mid-operation discards all entries at that edge, regardless of redirect or handshakes in the same cycle.
- The fetch slot holds a valid instruction in every cycle with reset=0.
- pop = d_valid & d_ready.
- push = !redirect & PC_enable.
- PC_enable = !reset & (redirect | count<DEPTH | pop). A full queue still accepts a push in the same cycle as a pop.
- next_PC = redirect ? redirect_target : f_PC_plus4.
- branch_taken = redirect & !reset.
- When PC_enable=0, fetch holds its PC. The same instruction is re-presented next cycle, so nothing is lost or duplicated.
- Latency: an instruction pushed at edge N is visible on d_* from cycle N+1 if the queue was empty. Throughput is 1 instr/cycle with d_ready held high.
- d_valid = (count!=0) & !redirect. d_* are driven from the head entry (registered storage, no combinational path from f_*).
- Stability: while d_valid=1 and d_ready=0, d_* are held constant until popped or flushed.
- Order: entries leave in fetch order.
- Redirect cycle:
  - d_valid is forced 0, so no pop occurs.
  - No push occurs; the wrong-path instruction is dropped.
  - PC_enable=1 and next_PC=redirect_target.
  - At the edge, pointers and count clear to 0.
  - Next cycle fetch presents the target, which is pushed normally.
- Redirect with count=0 behaves identically.
- Back-to-back redirects: each one reloads the PC; only the last target survives.
- Occupancy update (no reset, no redirect): push&!pop gives +1, pop&!push gives -1, both or neither gives no change. Count never exceeds DEPTH and never underflows.

Test Plan:
1. Stream: reset 2 cycles, release, d_ready=1.
   -> PC=0 pushed in the first cycle after release.
   -> d_PC = 0, 4, 8, 12 on consecutive cycles with d_valid=1, count=1 steady, PC_enable=1.
2. Backpressure: d_ready=0 from the first cycle after release.
   -> count 1 then 2, then PC_enable=0 with f_PC held at 8, and d_PC held at 0.
   -> Raise d_ready: d_PC = 0, 4, 8, 12 with no gap or duplicate.
3. Full plus simultaneous push/pop: count=2, d_ready=1.
   -> PC_enable=1, count stays 2, one entry leaves and one enters per cycle, pointers wrap correctly across more than 4 cycles.
4. Redirect: count=2, d_ready=0, redirect=1, redirect_target=0x40.
   -> That cycle: branch_taken=1, next_PC=0x40, PC_enable=1, d_valid=0.
   -> Next cycle: count=0, f_PC=0x40.
   -> Following cycle: d_valid=1, d_PC=0x40, d_PC_plus4=0x44.
5. Redirect concurrent with d_ready=1 at count=1.
   -> Head is not consumed (d_valid=0) and is discarded; the next d_PC seen is the target.
6. Reset mid-operation: count=2, assert reset one cycle together with redirect=1.
   -> Next cycle: count=0, d_valid=0. While reset is high, PC_enable=0 and branch_taken=0.

Source files
------------

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: buffers {PC, PC+4, instr} and closes the PC loop back to fetch.
// Latency: pushed at edge N, visible on d_* from cycle N+1; stalls fetch via PC_enable when full without a pop.
module fetch_decode_queue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      f_PC,
    input  logic [63:0]      f_PC_plus4,
    input  logic [31:0]      f_instruction,
    output logic             PC_enable,
    output logic [63:0]      next_PC,
    output logic             branch_taken,
    input  logic             redirect,
    input  logic [63:0]      redirect_target,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [63:0]      d_PC,
    output logic [63:0]      d_PC_plus4,
    output logic [31:0]      d_instruction,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] pc_plus4;
        logic [31:0] instr;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    // A full queue still accepts fetch when the head leaves in the same cycle.
    assign PC_enable    = !reset && (redirect || (count < CNT_W'(DEPTH)) || pop);
    assign next_PC      = redirect ? redirect_target : f_PC_plus4;
    assign branch_taken = redirect && !reset;

    assign d_valid = (count != '0) && !redirect;
    assign pop     = d_valid && d_ready;
    assign push    = !redirect && PC_enable;

    assign d_PC          = mem[rd_ptr].pc;
    assign d_PC_plus4    = mem[rd_ptr].pc_plus4;
    assign d_instruction = mem[rd_ptr].instr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: f_PC, pc_plus4: f_PC_plus4, instr: f_instruction};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed bench for fetch_decode_queue with a simple fetch-stage PC register model.
module tb_fetch_decode_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] f_pc;
    logic [63:0] f_PC_plus4;
    logic [31:0] f_instruction;
    logic        PC_enable;
    logic [63:0] next_PC;
    logic        branch_taken;
    logic        redirect = 1'b0;
    logic [63:0] redirect_target = '0;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic [63:0] d_PC;
    logic [63:0] d_PC_plus4;
    logic [31:0] d_instruction;
    logic [1:0]  count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h1300_0013;
    endfunction

    // Fetch stage: PC register loaded from next_PC when enabled.
    always_ff @(posedge clk) begin
        if (reset) f_pc <= '0;
        else if (PC_enable) f_pc <= next_PC;
    end
    assign f_PC_plus4    = f_pc + 64'd4;
    assign f_instruction = instr_of(f_pc);

    fetch_decode_queue #(.DEPTH(2), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .f_PC(f_pc), .f_PC_plus4(f_PC_plus4), .f_instruction(f_instruction),
        .PC_enable(PC_enable), .next_PC(next_PC), .branch_taken(branch_taken),
        .redirect(redirect), .redirect_target(redirect_target),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_PC(d_PC), .d_PC_plus4(d_PC_plus4), .d_instruction(d_instruction),
        .count(count)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++; if (PC_enable !== 1'b0) begin bad++; $display("FAIL rst_pc_en got=%b exp=0", PC_enable); end
        total++; if (branch_taken !== 1'b0) begin bad++; $display("FAIL rst_br got=%b exp=0", branch_taken); end
        cyc();
        cyc();
        total++; if (count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        total++; if (d_valid !== 1'b0) begin bad++; $display("FAIL rst_dvalid got=%b exp=0", d_valid); end
    endtask

    task automatic test_stream();
        d_ready = 1'b1;
        do_reset();
        total++; if (f_pc !== 64'd0 || PC_enable !== 1'b1) begin
            bad++; $display("FAIL stream_first f_PC=%h en=%b exp 0/1", f_pc, PC_enable);
        end
        cyc();
        for (int i = 0; i < 4; i++) begin
            total++; if (d_valid !== 1'b1 || d_PC !== 64'(4 * i) || count !== 2'd1 || PC_enable !== 1'b1) begin
                bad++; $display("FAIL stream_%0d vld=%b pc=%h cnt=%0d en=%b exp 1/%h/1/1", i, d_valid, d_PC, count, PC_enable, 64'(4 * i));
            end
            cyc();
        end
    endtask

    task automatic test_backpressure();
        d_ready = 1'b0;
        do_reset();
        total++; if (count !== 2'd0 || f_pc !== 64'd0) begin bad++; $display("FAIL bp_c0 cnt=%0d pc=%h exp 0/0", count, f_pc); end
        cyc();
        total++; if (count !== 2'd1 || d_PC !== 64'd0 || f_pc !== 64'd4) begin
            bad++; $display("FAIL bp_c1 cnt=%0d dpc=%h fpc=%h exp 1/0/4", count, d_PC, f_pc);
        end
        cyc();
        for (int i = 0; i < 2; i++) begin
            total++; if (count !== 2'd2 || PC_enable !== 1'b0 || f_pc !== 64'd8 || d_PC !== 64'd0) begin
                bad++; $display("FAIL bp_hold%0d cnt=%0d en=%b fpc=%h dpc=%h exp 2/0/8/0", i, count, PC_enable, f_pc, d_PC);
            end
            if (i == 0) cyc();
        end
        d_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++; if (d_valid !== 1'b1 || d_PC !== 64'(4 * i) || count !== 2'd2) begin
                bad++; $display("FAIL bp_drain%0d vld=%b pc=%h cnt=%0d exp 1/%h/2", i, d_valid, d_PC, count, 64'(4 * i));
            end
            cyc();
        end
    endtask

    // Continues from the full queue left by test_backpressure.
    task automatic test_full_push_pop();
        for (int i = 4; i < 10; i++) begin
            total++; if (d_PC !== 64'(4 * i) || d_PC_plus4 !== 64'(4 * i + 4) || d_instruction !== instr_of(64'(4 * i))
                         || count !== 2'd2 || PC_enable !== 1'b1 || d_valid !== 1'b1) begin
                bad++; $display("FAIL full%0d pc=%h p4=%h ins=%h cnt=%0d en=%b exp pc=%h cnt=2 en=1",
                                i, d_PC, d_PC_plus4, d_instruction, count, PC_enable, 64'(4 * i));
            end
            cyc();
        end
    endtask

    task automatic test_redirect();
        d_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        total++; if (count !== 2'd2) begin bad++; $display("FAIL redir_pre cnt=%0d exp 2", count); end
        redirect = 1'b1;
        redirect_target = 64'h40;
        #1;
        total++; if (branch_taken !== 1'b1 || next_PC !== 64'h40 || PC_enable !== 1'b1 || d_valid !== 1'b0) begin
            bad++; $display("FAIL redir_cyc br=%b npc=%h en=%b vld=%b exp 1/40/1/0", branch_taken, next_PC, PC_enable, d_valid);
        end
        cyc();
        redirect = 1'b0;
        #1;
        total++; if (count !== 2'd0 || f_pc !== 64'h40 || d_valid !== 1'b0) begin
            bad++; $display("FAIL redir_next cnt=%0d fpc=%h vld=%b exp 0/40/0", count, f_pc, d_valid);
        end
        cyc();
        total++; if (d_valid !== 1'b1 || d_PC !== 64'h40 || d_PC_plus4 !== 64'h44 || d_instruction !== instr_of(64'h40)) begin
            bad++; $display("FAIL redir_head vld=%b pc=%h p4=%h ins=%h exp 1/40/44", d_valid, d_PC, d_PC_plus4, d_instruction);
        end
    endtask

    task automatic test_redirect_with_ready();
        d_ready = 1'b1;
        do_reset();
        cyc();
        total++; if (count !== 2'd1 || d_PC !== 64'd0) begin bad++; $display("FAIL rr_pre cnt=%0d pc=%h exp 1/0", count, d_PC); end
        redirect = 1'b1;
        redirect_target = 64'h100;
        #1;
        total++; if (d_valid !== 1'b0 || PC_enable !== 1'b1) begin bad++; $display("FAIL rr_cyc vld=%b en=%b exp 0/1", d_valid, PC_enable); end
        cyc();
        redirect = 1'b0;
        #1;
        total++; if (count !== 2'd0 || f_pc !== 64'h100) begin bad++; $display("FAIL rr_next cnt=%0d fpc=%h exp 0/100", count, f_pc); end
        cyc();
        total++; if (d_valid !== 1'b1 || d_PC !== 64'h100) begin bad++; $display("FAIL rr_head vld=%b pc=%h exp 1/100", d_valid, d_PC); end
    endtask

    // Continues from test_redirect_with_ready: two redirects in consecutive cycles.
    task automatic test_back_to_back();
        redirect = 1'b1;
        redirect_target = 64'h200;
        #1;
        total++; if (next_PC !== 64'h200 || branch_taken !== 1'b1) begin bad++; $display("FAIL b2b_1 npc=%h br=%b exp 200/1", next_PC, branch_taken); end
        cyc();
        redirect_target = 64'h300;
        #1;
        total++; if (f_pc !== 64'h200 || next_PC !== 64'h300 || count !== 2'd0 || d_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_2 fpc=%h npc=%h cnt=%0d vld=%b exp 200/300/0/0", f_pc, next_PC, count, d_valid);
        end
        cyc();
        redirect = 1'b0;
        #1;
        total++; if (f_pc !== 64'h300 || count !== 2'd0) begin bad++; $display("FAIL b2b_3 fpc=%h cnt=%0d exp 300/0", f_pc, count); end
        cyc();
        total++; if (d_valid !== 1'b1 || d_PC !== 64'h300 || count !== 2'd1) begin
            bad++; $display("FAIL b2b_head vld=%b pc=%h cnt=%0d exp 1/300/1", d_valid, d_PC, count);
        end
    endtask

    task automatic test_reset_mid();
        d_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        total++; if (count !== 2'd2) begin bad++; $display("FAIL rm_pre cnt=%0d exp 2", count); end
        reset = 1'b1;
        redirect = 1'b1;
        redirect_target = 64'h80;
        #1;
        total++; if (PC_enable !== 1'b0 || branch_taken !== 1'b0) begin
            bad++; $display("FAIL rm_cyc en=%b br=%b exp 0/0", PC_enable, branch_taken);
        end
        cyc();
        reset = 1'b0;
        redirect = 1'b0;
        #1;
        total++; if (count !== 2'd0 || d_valid !== 1'b0 || f_pc !== 64'd0) begin
            bad++; $display("FAIL rm_next cnt=%0d vld=%b fpc=%h exp 0/0/0", count, d_valid, f_pc);
        end
        cyc();
        total++; if (d_valid !== 1'b1 || d_PC !== 64'd0 || count !== 2'd1) begin
            bad++; $display("FAIL rm_head vld=%b pc=%h cnt=%0d exp 1/0/1", d_valid, d_PC, count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_push_pop();
        test_redirect();
        test_redirect_with_ready();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
